fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined core. Holds the PC, drives the combinational instruction ROM address, and captures the returned word with its PC into an IF/ID output register. A one-entry skid buffer decouples the decode handshake, and branch/jump redirects from EX flush in-flight fetches. It sits directly upstream of the instruction ROM and feeds the decode stage.

Parameters:
A_WIDTH, 32, PC and ROM address width.
RESET_VECTOR, 32'hBFC00000, PC value after reset (base of the ROM window).
NOP_INSTR, 32'h00000013, instruction presented on id_instr when the output slot is invalid (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_en  in  1  global fetch enable; 0 freezes PC advance without dropping buffered words.
redirect_valid  in  1  taken branch/jump from EX, single-cycle pulse.
redirect_pc  in  A_WIDTH  target PC for redirect.
imem_addr  out  A_WIDTH  byte address to instruction ROM; equals pc_q (combinational).
imem_rdata  in  32  instruction word from ROM, valid in the same cycle as imem_addr.
id_valid  out  1  output slot holds a valid instruction.
id_ready  in  1  decode accepts the output slot this cycle.
id_instr  out  32  instruction to decode.
id_pc  out  A_WIDTH  PC of id_instr.
id_pc_plus4  out  A_WIDTH  id_pc + 4.
misalign_err  out  1  registered one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_VECTOR; out slot invalid with id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0; skid invalid; misalign_err=0. First fetch occurs on the first edge after deassertion.
- Storage: out slot {valid, instr, pc} feeds the id_* ports directly. Skid slot {valid, instr, pc} is internal.
- The word sent downstream is id_valid && id_ready.
- Fetch fires when fetch_en=1, skid empty, and redirect_valid=0. A fired fetch captures {imem_rdata, pc_q} and advances pc_q to pc_q+4 (wraps modulo 2^A_WIDTH).
- Fetched-word placement, evaluated in order:
  - Out slot empty, or out slot sent downstream while skid empty: the fetched word goes to the out slot.
  - Out slot full and not sent downstream: the fetched word goes to the skid.
- When the out slot is sent downstream and the skid is full: the skid moves to the out slot and no fetch fires (skid not empty this cycle).
- When the out slot is sent downstream, the skid is empty, and no fetch fires: the out slot becomes invalid.
- Fetch latency: PC presented at cycle N -> visible on id_* at cycle N+1. Sustained throughput is 1 instruction/cycle with id_ready=1.
- Redirect has priority over everything:
  - next pc_q = {redirect_pc[A_WIDTH-1:2], 2'b00}.
  - Out slot and skid are both invalidated.
  - The current ROM word is discarded, even if the out slot would have been sent downstream this cycle. Decode treats a redirect cycle as a flush.
  - misalign_err is set next cycle iff redirect_pc[1:0] != 0, otherwise cleared.
  - A redirect is honoured even when fetch_en=0.
- Invalid slots always drive id_instr=NOP_INSTR. id_pc and id_pc_plus4 hold their last values.
- id_pc_plus4 is registered alongside id_pc, not computed combinationally.
- fetch_en=0 with id_ready=1 drains the out slot, then the skid, then id_valid=0.
- Reset mid-stream: all buffered words are lost, the PC returns to RESET_VECTOR, and no partial state remains.

Decomposition:
- Shared package (core_pkg): RESET_VECTOR and NOP_INSTR constants, plus a typedef fetch_slot_t {logic valid; logic [31:0] instr; logic [A_WIDTH-1:0] pc;} reused by the decode-side pipeline register.
- One natural sub-module: fetch_skid_buf, the two-slot valid/ready buffer holding fetch_slot_t with flush input. The PC register and redirect logic stay in fetch_stage.

Test Plan:
- Reset then id_ready=1, fetch_en=1 -> id_pc sequence 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; id_instr matches the ROM words; id_pc_plus4=id_pc+4.
- Hold id_ready=0 for 3 cycles after the first valid word -> id_pc stays 0xBFC00000; skid holds 0xBFC00004; imem_addr stalls at 0xBFC00008. Release -> 0xBFC00004 then 0xBFC00008, nothing lost or duplicated.
- Redirect to 0xBFC00100 while skid full and id_ready=1 -> next cycle id_valid=0, id_instr=0x00000013; following cycle id_pc=0xBFC00100.
- Redirect to 0xBFC00102 -> misalign_err=1 for exactly one cycle; the following fetch uses PC 0xBFC00100.
- fetch_en=0 with both slots full and id_ready=1 -> two words delivered, then id_valid=0 and imem_addr unchanged. Redirect during fetch_en=0 still updates the PC.
- Assert rst_n=0 mid-stream asynchronously (between edges) -> id_valid=0 and imem_addr=0xBFC00000 immediately; after release the sequence restarts at 0xBFC00000.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: constants and the fetch slot type shared by fetch and decode.
package core_pkg;
    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic valid;
        logic [31:0] instr;
        logic [PC_WIDTH-1:0] pc;
    } fetch_slot_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: out slot plus one-entry skid, valid/ready toward decode, flushable.
module fetch_skid_buf
    import core_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  fetch_slot_t         in_slot,
    input  logic                out_ready,
    output fetch_slot_t         out_slot,
    output logic                skid_full,
    output logic                out_load,
    output logic [PC_WIDTH-1:0] load_pc
);
    fetch_slot_t skid_q;
    logic send;
    logic skid_load;

    always_comb begin
        send      = out_slot.valid && out_ready;
        out_load  = !flush && (skid_q.valid ? send : in_slot.valid && (!out_slot.valid || send));
        skid_load = !flush && !skid_q.valid && in_slot.valid && out_slot.valid && !send;
        load_pc   = skid_q.valid ? skid_q.pc : in_slot.pc;
        skid_full = skid_q.valid;
    end

    // Instr/pc fields are kept on flush so id_pc holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_slot <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            out_slot.valid <= 1'b0;
            skid_q.valid   <= 1'b0;
        end else begin
            if (out_load)
                out_slot <= skid_q.valid ? skid_q : in_slot;
            else if (send)
                out_slot.valid <= 1'b0;
            if (skid_load)
                skid_q <= in_slot;
            else if (skid_q.valid && send)
                skid_q.valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, ROM addressing and redirect handling feeding the IF/ID slot.
module fetch_stage
#(
    parameter int          A_WIDTH      = core_pkg::PC_WIDTH,
    parameter logic [31:0] RESET_VECTOR = core_pkg::RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = core_pkg::NOP_INSTR
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_pc,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_instr,
    output logic [A_WIDTH-1:0] id_pc,
    output logic [A_WIDTH-1:0] id_pc_plus4,
    output logic               misalign_err
);
    import core_pkg::fetch_slot_t;

    logic [A_WIDTH-1:0] pc_q;
    logic [A_WIDTH-1:0] pc4_q;
    logic [A_WIDTH-1:0] load_pc;
    logic               mis_q;
    logic               fire;
    logic               skid_full;
    logic               out_load;
    fetch_slot_t        in_slot;
    fetch_slot_t        out_slot;

    always_comb begin
        fire        = fetch_en && !skid_full && !redirect_valid;
        in_slot     = '{valid: fire, instr: imem_rdata, pc: pc_q};
        imem_addr   = pc_q;
        id_valid    = out_slot.valid;
        id_instr    = out_slot.valid ? out_slot.instr : NOP_INSTR;
        id_pc       = out_slot.pc;
        id_pc_plus4 = pc4_q;
        misalign_err = mis_q;
    end

    fetch_skid_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .in_slot   (in_slot),
        .out_ready (id_ready),
        .out_slot  (out_slot),
        .skid_full (skid_full),
        .out_load  (out_load),
        .load_pc   (load_pc)
    );

    // pc+4 travels with the out slot so decode sees it without an adder in its path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
            pc4_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= redirect_valid ? {redirect_pc[A_WIDTH-1:2], 2'b00}
                   : fire ? pc_q + A_WIDTH'(4) : pc_q;
            mis_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (out_load)
                pc4_q <= load_pc + A_WIDTH'(4);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus checked against a queue-based fetch model.
module tb_fetch_stage;
    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    word_t       mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_idpc;
    logic [31:0] m_idp4;
    logic        m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    assign imem_rdata = rom(imem_addr);

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .misalign_err   (misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RV;
        m_idpc = '0;
        m_idp4 = '0;
        m_mis  = 1'b0;
    endtask

    // The pipeline holds at most two words; the oldest is what decode sees.
    task automatic model_update();
        bit send;
        bit fire;
        send = (mq.size() > 0) && id_ready;
        if (redirect_valid) begin
            mq.delete();
            m_pc  = {redirect_pc[31:2], 2'b00};
            m_mis = redirect_pc[1:0] != 2'b00;
        end else begin
            m_mis = 1'b0;
            fire  = fetch_en && (mq.size() < 2);
            if (send) void'(mq.pop_front());
            if (fire) begin
                mq.push_back('{instr: rom(m_pc), pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        if (mq.size() > 0) begin
            m_idpc = mq[0].pc;
            m_idp4 = mq[0].pc + 32'd4;
        end
    endtask

    task automatic check_all();
        chk("id_valid", 32'(id_valid), 32'(mq.size() > 0));
        chk("id_instr", id_instr, mq.size() > 0 ? mq[0].instr : NOP);
        chk("id_pc", id_pc, m_idpc);
        chk("id_pc_plus4", id_pc_plus4, m_idp4);
        chk("imem_addr", imem_addr, m_pc);
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    endtask

    task automatic step(input logic en, input logic rv, input logic [31:0] rpc, input logic rdy);
        fetch_en       = en;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(id_valid), 32'd0);
        chk("async_rst_addr", imem_addr, RV);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(1, 0, 0, 1);
        chk("first_pc", id_pc, RV);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("stall_pc", id_pc, RV);
        chk("stall_addr", imem_addr, RV + 32'd8);
        step(1, 0, 0, 1);
        chk("drain_skid_pc", id_pc, RV + 32'd4);
        step(1, 0, 0, 1);
        chk("drain_next_pc", id_pc, RV + 32'd8);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 32'hBFC00100, 1);
        chk("flush_instr", id_instr, NOP);
        step(1, 0, 0, 1);
        chk("redirect_pc", id_pc, 32'hBFC00100);
        step(1, 1, 32'hBFC00102, 1);
        chk("misalign_set", 32'(misalign_err), 32'd1);
        step(1, 0, 0, 1);
        chk("misalign_clr", 32'(misalign_err), 32'd0);
        chk("misalign_pc", id_pc, 32'hBFC00100);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("drained_valid", 32'(id_valid), 32'd0);
        step(0, 1, 32'hBFC00200, 1);
        chk("redirect_no_en", imem_addr, 32'hBFC00200);
        step(0, 0, 0, 1);
        step(1, 1, 32'hFFFFFFF8, 1);
        repeat (4) step(1, 0, 0, 1);
        async_reset();
        step(1, 0, 0, 1);
        chk("restart_pc", id_pc, RV);
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350)
                async_reset();
            else
                step($urandom_range(0, 9) < 8,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 1) ? $urandom : RV + {$urandom_range(0, 255), 2'b00},
                     $urandom_range(0, 9) < 7);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
